// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_ctrl
// Description : Assembles UART bytes into SDRAM read/write command frames,
//               issues one req/ack memory access per frame and streams the
//               response bytes back toward the UART transmitter.
//               Optional frame checksum: define UART_CMD_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_ctrl #(
    parameter int ADDR_BYTES  = 3,
    parameter int DATA_BYTES  = 2,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [8*ADDR_BYTES-1:0] mem_addr,
    output logic [8*DATA_BYTES-1:0] mem_wdata,
    input  logic                    mem_ack,
    input  logic [8*DATA_BYTES-1:0] mem_rdata,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    busy,
    output logic                    err_timeout
);

    localparam int c_AW      = 8 * ADDR_BYTES;
    localparam int c_DW      = 8 * DATA_BYTES;
    localparam int c_CNT_MAX = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_TO_W    = $clog2(TIMEOUT_CYC + 1);

    localparam logic [c_CNT_W-1:0] c_ADDR_LAST = c_CNT_W'(ADDR_BYTES - 1);
    localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(DATA_BYTES - 1);
    localparam logic [c_TO_W-1:0]  c_TO_LAST   = c_TO_W'(TIMEOUT_CYC - 1);

    localparam logic [7:0] c_OP_WR   = 8'h57;
    localparam logic [7:0] c_OP_RD   = 8'h52;
    localparam logic [7:0] c_RSP_OK  = 8'h4B;
    localparam logic [7:0] c_RSP_BAD = 8'h3F;
`ifdef UART_CMD_CHECKSUM_EN
    localparam logic [7:0] c_RSP_CSUM = 8'h45;
`endif

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_ADDR     = 3'd1;
    localparam logic [2:0] c_DATA     = 3'd2;
    localparam logic [2:0] c_CSUM     = 3'd3;
    localparam logic [2:0] c_MEM_REQ  = 3'd4;
    localparam logic [2:0] c_MEM_WAIT = 3'd5;
    localparam logic [2:0] c_RESP     = 3'd6;

    logic [2:0]         r_state;
    logic               r_rx_d;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_TO_W-1:0]  r_to;
    logic [c_DW-1:0]    r_resp;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]         r_csum;
`endif

    logic            w_acc;
    logic            w_in_frame;
    logic            w_expire;
    logic [c_AW-1:0] w_rx_addr;
    logic [c_DW-1:0] w_rx_data;

    assign w_acc      = rx_valid & ~r_rx_d;
    assign w_in_frame = (r_state == c_ADDR) || (r_state == c_DATA) || (r_state == c_CSUM);
    assign w_expire   = w_in_frame && !w_acc && (r_to == c_TO_LAST);
    assign w_rx_addr  = c_AW'(rx_data);
    assign w_rx_data  = c_DW'(rx_data);
    assign busy       = (r_state != c_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_rx_d      <= 1'b1;
            r_cnt       <= '0;
            r_to        <= '0;
            r_resp      <= '0;
`ifdef UART_CMD_CHECKSUM_EN
            r_csum      <= '0;
`endif
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            r_rx_d      <= rx_valid;
            err_timeout <= 1'b0;

            // A byte arriving on the expiry cycle restarts the count instead of aborting
            if (w_acc || !w_in_frame)
                r_to <= '0;
            else if (!w_expire)
                r_to <= r_to + 1'b1;

            if (w_expire) begin
                r_state     <= c_IDLE;
                err_timeout <= 1'b1;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (w_acc) begin
                            if ((rx_data == c_OP_WR) || (rx_data == c_OP_RD)) begin
                                mem_we  <= (rx_data == c_OP_WR);
                                r_cnt   <= '0;
                                r_state <= c_ADDR;
`ifdef UART_CMD_CHECKSUM_EN
                                r_csum  <= rx_data;
`endif
                            end else begin
                                tx_data  <= c_RSP_BAD;
                                tx_valid <= 1'b1;
                                r_cnt    <= '0;
                                r_state  <= c_RESP;
                            end
                        end
                    end

                    c_ADDR: begin
                        if (w_acc) begin
                            mem_addr <= (mem_addr << 8) | w_rx_addr;
                            r_cnt    <= r_cnt + 1'b1;
`ifdef UART_CMD_CHECKSUM_EN
                            r_csum   <= r_csum ^ rx_data;
`endif
                            if (r_cnt == c_ADDR_LAST) begin
                                r_cnt <= '0;
                                if (mem_we) begin
                                    r_state <= c_DATA;
                                end else begin
`ifdef UART_CMD_CHECKSUM_EN
                                    r_state <= c_CSUM;
`else
                                    mem_req <= 1'b1;
                                    r_state <= c_MEM_REQ;
`endif
                                end
                            end
                        end
                    end

                    c_DATA: begin
                        if (w_acc) begin
                            mem_wdata <= (mem_wdata << 8) | w_rx_data;
                            r_cnt     <= r_cnt + 1'b1;
`ifdef UART_CMD_CHECKSUM_EN
                            r_csum    <= r_csum ^ rx_data;
`endif
                            if (r_cnt == c_DATA_LAST) begin
                                r_cnt <= '0;
`ifdef UART_CMD_CHECKSUM_EN
                                r_state <= c_CSUM;
`else
                                mem_req <= 1'b1;
                                r_state <= c_MEM_REQ;
`endif
                            end
                        end
                    end

`ifdef UART_CMD_CHECKSUM_EN
                    c_CSUM: begin
                        if (w_acc) begin
                            if (rx_data == r_csum) begin
                                mem_req <= 1'b1;
                                r_state <= c_MEM_REQ;
                            end else begin
                                tx_data  <= c_RSP_CSUM;
                                tx_valid <= 1'b1;
                                r_cnt    <= '0;
                                r_state  <= c_RESP;
                            end
                        end
                    end
`endif

                    c_MEM_REQ, c_MEM_WAIT: begin
                        r_state <= c_MEM_WAIT;
                        if (mem_ack) begin
                            mem_req  <= 1'b0;
                            tx_valid <= 1'b1;
                            r_state  <= c_RESP;
                            if (mem_we) begin
                                tx_data <= c_RSP_OK;
                                r_cnt   <= '0;
                            end else begin
                                // r_resp holds the bytes still queued behind tx_data
                                tx_data <= mem_rdata[c_DW-1 -: 8];
                                r_resp  <= mem_rdata << 8;
                                r_cnt   <= c_DATA_LAST;
                            end
                        end
                    end

                    c_RESP: begin
                        if (tx_valid && tx_ready) begin
                            if (r_cnt == '0) begin
                                tx_valid <= 1'b0;
                                r_state  <= c_IDLE;
                            end else begin
                                tx_data <= r_resp[c_DW-1 -: 8];
                                r_resp  <= r_resp << 8;
                                r_cnt   <= r_cnt - 1'b1;
                            end
                        end
                    end

                    default: r_state <= c_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_ctrl
// Description : Directed self-checking bench for uart_cmd_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_ctrl;

    localparam int c_TO = 20;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        mem_req;
    logic        mem_we;
    logic [23:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        err_timeout;

    int          n_tests;
    int          n_fail;
    int          err_cnt;
    logic [7:0]  tb_csum;

    uart_cmd_ctrl #(
        .ADDR_BYTES  (3),
        .DATA_BYTES  (2),
        .TIMEOUT_CYC (c_TO)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (err_timeout) err_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        tb_csum  = tb_csum ^ b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Closes a frame: sends the XOR byte only when the checksum feature is built in
    task automatic send_csum();
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(tb_csum);
`endif
        tb_csum = 8'h00;
    endtask

    task automatic do_ack(input logic [15:0] rd);
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = rd;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
    endtask

    task automatic expect_tx(input string tag, input logic [7:0] b);
        check({tag, "_valid"}, {31'd0, tx_valid}, 32'd1);
        check({tag, "_data"}, {24'd0, tx_data}, {24'd0, b});
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
    endtask

    initial begin
        int n;
        int err_base;
        n_tests   = 0;
        n_fail    = 0;
        err_cnt   = 0;
        tb_csum   = 8'h00;
        rst       = 1'b1;
        rx_valid  = 1'b1;
        rx_data   = 8'h41;
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
        tx_ready  = 1'b0;

        // rx_valid already high when reset lifts must not count as a byte
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_busy",     {31'd0, busy},        32'd0);
        check("rst_mem_req",  {31'd0, mem_req},     32'd0);
        check("rst_mem_we",   {31'd0, mem_we},      32'd0);
        check("rst_mem_addr", {8'd0, mem_addr},     32'd0);
        check("rst_wdata",    {16'd0, mem_wdata},   32'd0);
        check("rst_tx_valid", {31'd0, tx_valid},    32'd0);
        check("rst_tx_data",  {24'd0, tx_data},     32'd0);
        check("rst_err",      {31'd0, err_timeout}, 32'd0);
        rx_valid = 1'b0;

        // Stray ack while idle
        do_ack(16'hFFFF);
        check("idle_ack_busy", {31'd0, busy},     32'd0);
        check("idle_ack_tx",   {31'd0, tx_valid}, 32'd0);

        // Write frame
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h01); send_byte(8'h02);
        send_byte(8'hAB); send_byte(8'hCD); send_csum();
        check("wr_req",   {31'd0, mem_req},   32'd1);
        check("wr_we",    {31'd0, mem_we},    32'd1);
        check("wr_addr",  {8'd0, mem_addr},   32'h000102);
        check("wr_wdata", {16'd0, mem_wdata}, 32'hABCD);
        repeat (5) @(negedge clk);
        check("wr_req_hold",  {31'd0, mem_req}, 32'd1);
        check("wr_addr_hold", {8'd0, mem_addr}, 32'h000102);
        do_ack(16'h0000);
        check("wr_req_drop", {31'd0, mem_req}, 32'd0);
        expect_tx("wr_k", 8'h4B);
        check("wr_tx_done", {31'd0, tx_valid}, 32'd0);
        check("wr_idle",    {31'd0, busy},     32'd0);

        // Read frame with back-pressure on the first response byte
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
        send_csum();
        check("rd_req",  {31'd0, mem_req}, 32'd1);
        check("rd_we",   {31'd0, mem_we},  32'd0);
        check("rd_addr", {8'd0, mem_addr}, 32'h000010);
        do_ack(16'h1234);
        check("rd_b0_data", {24'd0, tx_data}, 32'h12);
        repeat (3) @(negedge clk);
        check("rd_b0_hold_valid", {31'd0, tx_valid}, 32'd1);
        check("rd_b0_hold_data",  {24'd0, tx_data},  32'h12);
        tx_ready = 1'b1;
        @(negedge clk);
        check("rd_b1_valid", {31'd0, tx_valid}, 32'd1);
        check("rd_b1_data",  {24'd0, tx_data},  32'h34);
        @(negedge clk);
        tx_ready = 1'b0;
        check("rd_tx_done", {31'd0, tx_valid}, 32'd0);
        check("rd_idle",    {31'd0, busy},     32'd0);

        // Unknown opcode, then a normal frame
        send_byte(8'h41);
        tb_csum = 8'h00;
        check("bad_req", {31'd0, mem_req}, 32'd0);
        expect_tx("bad_q", 8'h3F);
        check("bad_idle", {31'd0, busy}, 32'd0);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
        send_csum();
        check("bad_next_req",  {31'd0, mem_req}, 32'd1);
        check("bad_next_addr", {8'd0, mem_addr}, 32'h000010);
        do_ack(16'hBEEF);
        expect_tx("bad_next_b0", 8'hBE);
        expect_tx("bad_next_b1", 8'hEF);
        check("bad_next_done", {31'd0, tx_valid}, 32'd0);

        // Inter-byte timeout
        err_base = err_cnt;
        send_byte(8'h57); send_byte(8'h00);
        tb_csum = 8'h00;
        n = 0;
        for (int i = 0; i < 4 * c_TO; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (err_timeout) break;
        end
        check("to_latency", n, c_TO);
        check("to_pulse",   {31'd0, err_timeout}, 32'd1);
        check("to_busy",    {31'd0, busy},        32'd0);
        @(posedge clk);
        #1;
        check("to_pulse_end", {31'd0, err_timeout}, 32'd0);
        check("to_no_req",    {31'd0, mem_req},     32'd0);
        check("to_no_tx",     {31'd0, tx_valid},    32'd0);
        check("to_count",     err_cnt - err_base,   32'd1);

        // Byte landing on the expiry cycle keeps the frame alive
        err_base = err_cnt;
        send_byte(8'h57);
        repeat (c_TO - 2) @(negedge clk);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
        send_byte(8'h11); send_byte(8'h22); send_csum();
        check("edge_no_err", err_cnt - err_base, 32'd0);
        check("edge_req",    {31'd0, mem_req},   32'd1);
        check("edge_addr",   {8'd0, mem_addr},   32'h000020);
        check("edge_wdata",  {16'd0, mem_wdata}, 32'h1122);
        do_ack(16'h0000);
        expect_tx("edge_k", 8'h4B);

        // Reset while waiting on memory; a late ack must be ignored
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h30);
        send_csum();
        repeat (2) @(negedge clk);
        check("rw_req_before", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rw_req_after",  {31'd0, mem_req}, 32'd0);
        check("rw_busy_after", {31'd0, busy},    32'd0);
        check("rw_addr_after", {8'd0, mem_addr}, 32'd0);
        do_ack(16'h5678);
        check("rw_late_ack_tx",   {31'd0, tx_valid}, 32'd0);
        check("rw_late_ack_busy", {31'd0, busy},     32'd0);

`ifdef UART_CMD_CHECKSUM_EN
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
        send_byte(8'h42);
        tb_csum = 8'h00;
        check("cs_ok_req", {31'd0, mem_req}, 32'd1);
        do_ack(16'hA55A);
        expect_tx("cs_ok_b0", 8'hA5);
        expect_tx("cs_ok_b1", 8'h5A);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
        send_byte(8'h00);
        tb_csum = 8'h00;
        check("cs_bad_req", {31'd0, mem_req}, 32'd0);
        expect_tx("cs_bad_e", 8'h45);
        check("cs_bad_idle", {31'd0, busy}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
Command sequencer between the UART receive path and the SDRAM controller's user port. It assembles received bytes into read/write command frames and issues one memory request per frame over a req/ack handshake. It then returns a response byte stream toward the UART transmitter using a valid/ready handshake. It is the single bridge that lets a host PC exercise SDRAM over the serial link.

Parameters:
ADDR_BYTES, 3, address bytes per frame (MSB first); mem_addr width = 8*ADDR_BYTES
DATA_BYTES, 2, data bytes per word (MSB first); mem_wdata/mem_rdata width = 8*DATA_BYTES
TIMEOUT_CYC, 100000, max clk cycles allowed between bytes inside a frame before abort

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
rx_data  in  8  received byte from UART receiver
rx_valid  in  1  level from receiver; a byte is accepted on its rising edge (rx_data sampled that cycle)
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1 = write, 0 = read; stable while mem_req
mem_addr  out  8*ADDR_BYTES  request address; stable while mem_req
mem_wdata  out  8*DATA_BYTES  write data; stable while mem_req
mem_ack  in  1  one-cycle completion pulse; ignored unless mem_req=1
mem_rdata  in  8*DATA_BYTES  read data, valid in the mem_ack cycle
tx_data  out  8  response byte
tx_valid  out  1  response byte valid; held with tx_data stable until tx_ready
tx_ready  in  1  transmitter accepts byte when tx_valid & tx_ready
busy  out  1  high in every state except IDLE
err_timeout  out  1  one-cycle pulse on inter-byte timeout abort

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, tx_valid=0, tx_data=0, busy=0, err_timeout=0, rx edge detector primed with rx_valid history=1 (a level already high at reset exit is not a byte).
- Byte accept: acc = rx_valid & ~rx_valid_d. Only acted on in IDLE/ADDR/DATA/CSUM; otherwise silently dropped.
- Frame format: opcode, ADDR_BYTES address, then (write only) DATA_BYTES data, then optional checksum.
  - Opcodes: 0x57 'W' = write; 0x52 'R' = read.
- States:
  - IDLE: on acc, 'W'/'R' -> ADDR (latch mem_we); any other byte -> RESP with single byte 0x3F '?'.
  - ADDR: shift byte into mem_addr (MSB first); after ADDR_BYTES bytes -> DATA if write, else CSUM/MEM_REQ.
  - DATA: shift into mem_wdata; after DATA_BYTES bytes -> CSUM/MEM_REQ.
  - MEM_REQ: mem_req=1 asserted in the cycle after the final byte is accepted; -> MEM_WAIT.
  - MEM_WAIT: mem_req stays 1 until the cycle mem_ack=1. Capture mem_rdata on read. mem_req=0 the next cycle; -> RESP.
    - No timeout here; waits indefinitely.
  - RESP: write -> one byte 0x4B 'K'; read -> DATA_BYTES bytes of captured data, MSB first.
    - Each byte is held until tx_ready. After the last transfer -> IDLE; tx_valid=0 the next cycle.
- Timeout: counter cleared on each acc and in IDLE, counts in ADDR/DATA/CSUM. On reaching TIMEOUT_CYC-1 without acc: -> IDLE, err_timeout=1 for one cycle, partial frame discarded, no response.
  - acc in the same cycle as expiry: acc wins, counter clears.
- mem_ack while mem_req=0: ignored.
- tx_ready while tx_valid=0: ignored.
- rst mid-frame or mid-request: returns to IDLE next edge with all outputs at reset values. An outstanding memory request is abandoned; the controller must tolerate the request dropping.
- Byte counter width: clog2(max(ADDR_BYTES,DATA_BYTES)+1); wraps never (reset on each state entry).

Optional Feature:
UART_CMD_CHECKSUM_EN
- Defined: CSUM state follows the last address/data byte and expects one byte equal to the XOR of all preceding frame bytes (opcode included).
  - Match -> MEM_REQ.
  - Mismatch -> RESP with single byte 0x45 'E', no memory access.
  - Timeout applies in CSUM.
- Undefined: no CSUM state; frame ends at the last address/data byte.

Test Plan:
- Write (no checksum): bytes 57 00 01 02 AB CD -> mem_req with we=1, addr=0x000102, wdata=0xABCD. Ack after 5 cycles -> tx byte 0x4B.
- Read: bytes 52 00 00 10, mem_rdata=0x1234 on ack -> tx bytes 0x12 then 0x34. tx_ready held low 3 cycles on the first byte -> tx_data stays 0x12.
- Bad opcode 0x41 -> tx 0x3F, no mem_req. The following byte 52 starts a new frame normally.
- Timeout: 57 00 then silence TIMEOUT_CYC cycles -> err_timeout pulse, back to IDLE, no mem_req, no tx.
- rst asserted during MEM_WAIT -> next cycle mem_req=0, busy=0. A late mem_ack is ignored.
- With UART_CMD_CHECKSUM_EN: 52 00 00 10 42 -> read proceeds; 52 00 00 10 00 -> tx 0x45, no mem_req.
